bcd_down_timer: RTL
===================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 The block SHALL provide parameter DIGITS, default 2, giving the number of BCD digits in the counter (legal range 1..4).
REQ-002 The block SHALL provide parameter AUTO_RELOAD, default 1: 1 reloads the last loaded value after reaching zero, 0 stops at zero.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-005 The block SHALL have port load, input, 1 bit: parallel-load strobe, sampled on the rising edge of clk.
REQ-006 The block SHALL have port load_val, input, 4*DIGITS bits: BCD load value, with digit 0 in bits [3:0].
REQ-007 The block SHALL have port en, input, 1 bit: count enable.
REQ-008 The block SHALL have port count, output, 4*DIGITS bits: current BCD count, registered.
REQ-009 The block SHALL have port zero, output, 1 bit, which is high whenever count equals 0.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking terminal count.
REQ-011 The block SHALL have port busy, output, 1 bit, which is high while the state is RUN.
REQ-012 The block SHALL have port load_err, output, 1 bit: a sticky flag for an invalid-BCD load attempt.

Function
REQ-013 The block SHALL implement two states, IDLE and RUN, and hold an internal reload register of 4*DIGITS bits.
REQ-014 A load value SHALL be valid only if every nibble of load_val is at most 9.
REQ-015 On a valid load, the block SHALL set count and the reload register to load_val and clear load_err. The next state SHALL be RUN if load_val is nonzero and IDLE if it is zero. done SHALL be 0 that cycle.
REQ-016 On an invalid load, the block SHALL set load_err to 1 and leave count, the reload register and the state unchanged.
REQ-017 load SHALL take priority over en and over terminal-count handling in the same cycle.
REQ-018 When the state is RUN, en is 1, load is 0 and count is nonzero, the block SHALL decrement count by 1 in BCD:
- a nonzero digit decrements by 1;
- a zero digit becomes 9 and borrows from the next higher digit;
- every nibble of count SHALL always hold a value of 9 or less.
REQ-019 When that decrement produces 0, done SHALL be 1 in the same cycle that count first reads 0, and for that single cycle only.
REQ-020 With AUTO_RELOAD=1, state RUN, count=0, en=1 and load=0, the block SHALL set count to the reload register value, stay in RUN, and drive done low.
- Resulting period: reload value + 1 enabled cycles.
- Example: load 9 gives a done pulse every 10 enabled cycles.
REQ-021 With AUTO_RELOAD=0, reaching 0 SHALL move the state to IDLE. count SHALL then hold 0 and en SHALL be ignored until the next valid load.
REQ-022 When en=0 and load=0, the block SHALL hold count and the state, and drive done low.
REQ-023 In IDLE, the block SHALL never decrement and SHALL never assert done.
REQ-024 zero SHALL be derived from the count register only, with no dependence on inputs.
REQ-025 A load of 0 while in RUN SHALL move the state to IDLE without a done pulse.

Reset
REQ-026 When rst is low, the block SHALL immediately, without waiting for clk, drive count=0, the reload register=0, state=IDLE, zero=1, done=0, busy=0 and load_err=0.
REQ-027 A reset asserted mid-count SHALL abort the count. After rst is released, the block SHALL stay in IDLE until a valid load.
REQ-028 The first rising edge of clk with rst high SHALL be able to accept a load.

Verification
REQ-029 DIGITS=2, AUTO_RELOAD=1; load 09, then en=1 for 30 cycles -> count runs 09,08..00,09,...; done pulses exactly 3 times, 10 cycles apart; busy stays 1.
REQ-030 Load 10, then en=1 -> count reads 10, 09 (borrow), 08; load 00 -> count 00, zero=1, busy=0, no done pulse.
REQ-031 Load 3A -> load_err=1, and count and state are unchanged; then load 05 -> load_err=0, count=05.
REQ-032 AUTO_RELOAD=0; load 02, then en=1 for 6 cycles -> count reads 02,01,00; one done pulse; busy=0 afterwards; count holds 00.
REQ-033 Load 07, then toggle en every other cycle -> count decrements only on en=1 cycles; a load asserted together with en at count 00 loads the new value and produces no reload.
REQ-034 Assert rst low mid-count, away from a clk edge -> all outputs take their reset values immediately; after release the count stays 00 with en=1 until a load.

Source files
------------

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable BCD down counter with optional auto-reload and a terminal-count pulse
module bcd_down_timer #(
  parameter int DIGITS = 2,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  done,
  output logic                  busy,
  output logic                  load_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nxt_state;
  logic [4*DIGITS-1:0] reload, nxt_count, nxt_reload, dec;
  logic [DIGITS-1:0] ok, b;
  logic nxt_done, nxt_err;
  for (genvar i = 0; i < DIGITS; i++) begin : g
    assign ok[i] = load_val[4*i+:4] <= 4'd9;
    if (i == 0) begin : lo
      assign b[i] = 1'b1;
    end else begin : hi
      assign b[i] = ~|count[4*i-1:0];
    end
    assign dec[4*i+:4] = !b[i] ? count[4*i+:4] : (count[4*i+:4] == 4'd0) ? 4'd9 : count[4*i+:4] - 4'd1;
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= nxt_state;
      count    <= nxt_count;
      reload   <= nxt_reload;
      done     <= nxt_done;
      load_err <= nxt_err;
    end
  end
  // next state: load wins, then decrement or reload while running and enabled
  always_comb begin
    nxt_state  = state;
    nxt_count  = count;
    nxt_reload = reload;
    nxt_done   = 1'b0;
    nxt_err    = load_err;
    if (load) begin
      if (&ok) begin
        nxt_count  = load_val;
        nxt_reload = load_val;
        nxt_err    = 1'b0;
        nxt_state  = |load_val ? RUN : IDLE;
      end else begin
        nxt_err = 1'b1;
      end
    end else if (state == RUN && en) begin
      if (|count) begin
        nxt_count = dec;
        nxt_done  = ~|dec;
        if (!AUTO_RELOAD && ~|dec) nxt_state = IDLE;
      end else if (AUTO_RELOAD) begin
        nxt_count = reload;
      end else begin
        nxt_state = IDLE;
      end
    end
  end
  // status outputs decoded from registered state only
  always_comb begin
    zero = ~|count;
    busy = state == RUN;
  end
endmodule
